mod_counter_311: RTL and testbench

Parametrised up/down modulo counter; the next generation of the lab's fixed 8-bit up counter. Adds configurable width and modulus, direction control, count enable, synchronous parallel load, a wrap-or-saturate mode, a terminal-count pulse and a sticky overflow flag. Used as the general-purpose counting element in the counters lab set, replacing fixed-width up-only counters.

---
 rtl/counter_311_pkg.sv | 13 +
 rtl/mod_counter_311.sv | 81 ++++++++
 tb/tb_mod_counter_311.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/counter_311_pkg.sv
// rtl/counter_311_pkg.sv - shared constants and helpers for the 311 counter family
package counter_311_pkg;

    localparam logic DIR_UP_311   = 1'b1;
    localparam logic DIR_DOWN_311 = 1'b0;

    // Operands are zero-extended to 33 bits so any WIDTH up to 32 plus a guard bit fits.
    function automatic logic [32:0] clamp_to_max_311(input logic [32:0] val,
                                                     input logic [32:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/mod_counter_311.sv
// rtl/mod_counter_311.sv - up/down modulo counter with load, saturate, tc pulse and sticky overflow
module mod_counter_311
    import counter_311_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk_311,
    input  logic             reset_311,
    input  logic             en_311,
    input  logic             up_311,
    input  logic             load_311,
    input  logic [WIDTH-1:0] load_val_311,
    input  logic             clr_ovf_311,
    output logic [WIDTH-1:0] count_311,
    output logic             tc_311,
    output logic             ovf_311
);

    generate
        if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
            $error("mod_counter_311: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    // One guard bit keeps MAX+1 and 0-1 distinct from legal counts for any MODULUS.
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH:0] ZERO_W = '0;

    logic [WIDTH:0] count_ext;
    logic           at_max;
    logic           at_zero;
    logic [WIDTH:0] up_next;
    logic [WIDTH:0] down_next;
    logic [WIDTH:0] step_next;
    logic           boundary;
    logic [32:0]    load_clamp_full;
    logic [WIDTH-1:0] load_next;
    logic           unused_clamp_hi;

    assign count_ext = {1'b0, count_311};
    assign at_max    = (count_ext == MAX_W);
    assign at_zero   = (count_ext == ZERO_W);

    assign up_next   = at_max  ? (SATURATE ? MAX_W : ZERO_W) : count_ext + 1'b1;
    assign down_next = at_zero ? (SATURATE ? ZERO_W : MAX_W) : count_ext - 1'b1;
    assign step_next = (up_311 == DIR_UP_311) ? up_next : down_next;

    // A load cycle never counts, so it can never be a boundary event.
    assign boundary  = en_311 && !load_311 && ((up_311 == DIR_UP_311) ? at_max : at_zero);

    assign load_clamp_full = clamp_to_max_311(33'(load_val_311), 33'(MAX_W));
    assign load_next       = load_clamp_full[WIDTH-1:0];
    assign unused_clamp_hi = ^load_clamp_full[32:WIDTH];

    always_ff @(posedge clk_311) begin
        if (reset_311) begin
            count_311 <= '0;
        end else if (load_311) begin
            count_311 <= load_next;
        end else if (en_311) begin
            count_311 <= step_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_311) begin
        if (reset_311) begin
            tc_311  <= 1'b0;
            ovf_311 <= 1'b0;
        end else begin
            tc_311 <= boundary;
            if (boundary) begin
                ovf_311 <= 1'b1;
            end else if (clr_ovf_311) begin
                ovf_311 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_counter_311.sv
// tb/tb_mod_counter_311.sv - directed self-checking bench for mod_counter_311 (wrap and saturate builds)
module tb_mod_counter_311;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic             w_en = 0, w_up = 1, w_load = 0, w_clr = 0;
    logic [WIDTH-1:0] w_load_val = '0;
    logic [WIDTH-1:0] w_count;
    logic             w_tc, w_ovf;

    logic             s_en = 0, s_up = 1, s_load = 0, s_clr = 0;
    logic [WIDTH-1:0] s_load_val = '0;
    logic [WIDTH-1:0] s_count;
    logic             s_tc, s_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mod_counter_311 #(.WIDTH(WIDTH), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
        .clk_311(clk), .reset_311(reset), .en_311(w_en), .up_311(w_up),
        .load_311(w_load), .load_val_311(w_load_val), .clr_ovf_311(w_clr),
        .count_311(w_count), .tc_311(w_tc), .ovf_311(w_ovf)
    );

    mod_counter_311 #(.WIDTH(WIDTH), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
        .clk_311(clk), .reset_311(reset), .en_311(s_en), .up_311(s_up),
        .load_311(s_load), .load_val_311(s_load_val), .clr_ovf_311(s_clr),
        .count_311(s_count), .tc_311(s_tc), .ovf_311(s_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w(input string tag, input int c, input bit tc, input bit ovf);
        check_eq({tag, ".count"}, 32'(w_count), 32'(c));
        check_eq({tag, ".tc"},    32'(w_tc),    32'(tc));
        check_eq({tag, ".ovf"},   32'(w_ovf),   32'(ovf));
    endtask

    task automatic check_s(input string tag, input int c, input bit tc, input bit ovf);
        check_eq({tag, ".count"}, 32'(s_count), 32'(c));
        check_eq({tag, ".tc"},    32'(s_tc),    32'(tc));
        check_eq({tag, ".ovf"},   32'(s_ovf),   32'(ovf));
    endtask

    initial begin
        step();
        check_w("reset_w", 0, 0, 0);
        check_s("reset_s", 0, 0, 0);
        reset = 0;

        // Up count 0..9 then wrap to 0 with tc and ovf.
        w_en = 1; w_up = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_w($sformatf("up%0d", i), i % 10, i == 10, i == 10);
        end
        step();
        check_w("up_after_wrap", 1, 0, 1);

        // Down count with wrap 2,1,0,9, then direction change wraps 9->0.
        w_en = 0; w_load = 1; w_load_val = 2;
        step();
        check_w("load2", 2, 0, 1);
        w_load = 0; w_en = 1; w_up = 0;
        step(); check_w("dn1", 1, 0, 1);
        step(); check_w("dn0", 0, 0, 1);
        step(); check_w("dn_wrap", 9, 1, 1);
        w_up = 1;
        step(); check_w("dir_up_wrap", 0, 1, 1);

        // Clear overflow.
        w_en = 0; w_clr = 1;
        step(); check_w("clr_ovf", 0, 0, 0);
        w_clr = 0;

        // Load with enable: clamp, no step, no tc.
        w_en = 1; w_load = 1; w_load_val = 15;
        step(); check_w("load_clamp", 9, 0, 0);
        w_load = 0;

        // Clear on the same edge as a wrap: set wins.
        w_clr = 1;
        step(); check_w("clr_vs_wrap", 0, 1, 1);
        w_clr = 0;

        // Load keeps ovf; then count to 5 and reset mid-operation.
        w_en = 0; w_load = 1; w_load_val = 3;
        step(); check_w("load3_keep_ovf", 3, 0, 1);
        w_load = 0; w_en = 1; w_up = 1;
        step(); check_w("to4", 4, 0, 1);
        step(); check_w("to5", 5, 0, 1);
        reset = 1; w_load = 1; w_load_val = 7; w_clr = 0;
        step(); check_w("mid_reset", 0, 0, 0);
        reset = 0; w_load = 0;
        step(); check_w("resume1", 1, 0, 0);
        step(); check_w("resume2", 2, 0, 0);
        w_en = 0;
        step(); check_w("hold", 2, 0, 0);

        // Saturating build: hold at MAX with tc every hold cycle.
        check_s("sat_idle", 0, 0, 0);
        s_load = 1; s_load_val = 8;
        step(); check_s("sat_load8", 8, 0, 0);
        s_load = 0; s_en = 1; s_up = 1;
        step(); check_s("sat_up9", 9, 0, 0);
        step(); check_s("sat_hold1", 9, 1, 1);
        step(); check_s("sat_hold2", 9, 1, 1);
        s_en = 0; s_clr = 1;
        step(); check_s("sat_clr", 9, 0, 0);
        s_clr = 0;
        s_load = 1; s_load_val = 0;
        step(); check_s("sat_load0", 0, 0, 0);
        s_load = 0; s_en = 1; s_up = 0;
        step(); check_s("sat_low1", 0, 1, 1);
        step(); check_s("sat_low2", 0, 1, 1);
        s_up = 1;
        step(); check_s("sat_leave", 1, 0, 1);
        s_en = 0;
        step(); check_s("sat_idle_tc", 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
